cv32e40px_xif_copro_ctrl: RTL and testbench

Coprocessor-side responder for the CORE-V-XIF issue, commit and result interfaces of the cv32e40px core. It decodes offloaded custom-0 instructions, accepts or rejects them, and computes a 3-operand integer result at issue time. Results are held in an in-order buffer until the core commits or kills each instruction, then written back through the result channel. It sits outside the core, beside any other coprocessors on the same XIF bus; memory and compressed channels are not used.

---
 rtl/cv32e40px_core_v_xif_pkg.sv | 73 +++++++
 rtl/cv32e40px_xif_copro_ctrl_if.sv | 26 ++
 rtl/cv32e40px_xif_copro_alu.sv | 44 ++++
 rtl/cv32e40px_xif_copro_ctrl.sv | 147 ++++++++++++++
 tb/tb_cv32e40px_xif_copro_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40px_core_v_xif_pkg.sv
// CORE-V-XIF shared types for cv32e40px, plus the custom-0 coprocessor
// opcode, op encoding and result-buffer entry used by the XIF coprocessor.
package cv32e40px_core_v_xif_pkg;

  localparam int X_NUM_RS    = 3;
  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFR_WIDTH = 32;
  localparam int X_RFW_WIDTH = 32;
  localparam int X_DUALWRITE = 0;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [1:0]                           mode;
    logic [X_ID_WIDTH-1:0]                id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [X_NUM_RS-1:0]                  rs_valid;
    logic [5:0]                           ecs;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]                   id;
    logic [X_DUALWRITE:0][X_RFW_WIDTH-1:0]   data;
    logic [4:0]                              rd;
    logic [X_DUALWRITE:0]                    we;
    logic [2:0]                              ecswe;
    logic [5:0]                              ecsdata;
    logic                                    exc;
    logic [5:0]                              exccode;
    logic                                    err;
    logic                                    dbg;
  } x_result_t;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    OP_ADD3 = 3'b000,
    OP_MIN  = 3'b001,
    OP_MAX  = 3'b010,
    OP_XOR3 = 3'b011
  } copro_op_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   committed;
    logic                   killed;
  } copro_entry_t;

  // Three-operand ops need rs3; the compare ops only read rs1/rs2.
  function automatic logic [X_NUM_RS-1:0] copro_req_mask(input copro_op_e op);
    case (op)
      OP_ADD3, OP_XOR3: return 3'b111;
      default:          return 3'b011;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40px_xif_copro_ctrl_if.sv
// Issue/commit/result bundle between the core (master) and the coprocessor (slave).
interface cv32e40px_xif_copro_ctrl_if;
  import cv32e40px_core_v_xif_pkg::*;

  logic          issue_valid;
  logic          issue_ready;
  x_issue_req_t  issue_req;
  x_issue_resp_t issue_resp;
  logic          commit_valid;
  x_commit_t     commit;
  logic          result_valid;
  logic          result_ready;
  x_result_t     result;
  logic          busy;

  modport master (
    output issue_valid, issue_req, commit_valid, commit, result_ready,
    input  issue_ready, issue_resp, result_valid, result, busy
  );

  modport slave (
    input  issue_valid, issue_req, commit_valid, commit, result_ready,
    output issue_ready, issue_resp, result_valid, result, busy
  );

endinterface

// File: rtl/cv32e40px_xif_copro_alu.sv
// Combinational decode and datapath for the custom-0 three-operand ops.
module cv32e40px_xif_copro_alu
  import cv32e40px_core_v_xif_pkg::*;
(
  input  logic [31:0]                          instr_i,
  input  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs_i,
  output logic                                 accept_o,
  output logic                                 writeback_o,
  output logic [4:0]                           rd_o,
  output logic [X_NUM_RS-1:0]                  req_mask_o,
  output logic [X_RFW_WIDTH-1:0]               result_o
);

  copro_op_e              op;
  logic [X_RFR_WIDTH-1:0] rs1;
  logic [X_RFR_WIDTH-1:0] rs2;
  logic [X_RFR_WIDTH-1:0] rs3;
  logic                   unused_instr_bits;

  assign op   = copro_op_e'(instr_i[14:12]);
  assign rs1  = rs_i[0];
  assign rs2  = rs_i[1];
  assign rs3  = rs_i[2];
  assign rd_o = instr_i[11:7];

  // funct3[2]=1 selects nothing we implement.
  assign accept_o    = (instr_i[6:0] == OPCODE_CUSTOM0) && (instr_i[31:25] == 7'd0) && !instr_i[14];
  assign writeback_o = accept_o && (rd_o != 5'd0);
  assign req_mask_o  = copro_req_mask(op);

  assign unused_instr_bits = ^instr_i[24:15];

  always_comb begin
    result_o = '0;
    case (op)
      OP_ADD3: result_o = rs1 + rs2 + rs3;
      OP_MIN:  result_o = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;
      OP_MAX:  result_o = ($signed(rs1) < $signed(rs2)) ? rs2 : rs1;
      OP_XOR3: result_o = rs1 ^ rs2 ^ rs3;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/cv32e40px_xif_copro_ctrl.sv
// XIF coprocessor responder: accepts custom-0 ops, computes at issue time and
// holds results in an in-order buffer until the core commits or kills them.
module cv32e40px_xif_copro_ctrl
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  cv32e40px_xif_copro_ctrl_if.slave xif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic                   alu_accept;
  logic                   alu_writeback;
  logic [4:0]             alu_rd;
  logic [X_NUM_RS-1:0]    alu_req_mask;
  logic [X_RFW_WIDTH-1:0] alu_result;

  logic             ops_ready;
  logic             has_room;
  logic             push;
  logic             pop;
  logic             commit_new;
  logic             head_valid;
  logic             result_valid;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_en_q;
  logic             unused_req_bits;

  copro_entry_t new_entry;
  copro_entry_t head_entry;
  copro_entry_t entries [DEPTH];

  cv32e40px_xif_copro_alu u_alu (
    .instr_i     (xif.issue_req.instr),
    .rs_i        (xif.issue_req.rs),
    .accept_o    (alu_accept),
    .writeback_o (alu_writeback),
    .rd_o        (alu_rd),
    .req_mask_o  (alu_req_mask),
    .result_o    (alu_result)
  );

  assign unused_req_bits = ^{xif.issue_req.mode, xif.issue_req.ecs};

  // Rejections never stall; accepts wait for operands and a free slot.
  // A same-cycle pop does not count as a free slot.
  assign ops_ready       = &(xif.issue_req.rs_valid | ~alu_req_mask);
  assign has_room        = count_q < DEPTH_C;
  assign xif.issue_ready = ready_en_q && (!alu_accept || (ops_ready && has_room));

  always_comb begin
    xif.issue_resp           = '0;
    xif.issue_resp.accept    = alu_accept;
    xif.issue_resp.writeback = alu_writeback;
  end

  assign push       = xif.issue_valid && xif.issue_ready && alu_accept;
  assign commit_new = push && xif.commit_valid && (xif.commit.id == xif.issue_req.id);

  always_comb begin
    new_entry           = '0;
    new_entry.id        = xif.issue_req.id;
    new_entry.data      = alu_result;
    new_entry.rd        = alu_rd;
    new_entry.committed = commit_new;
    new_entry.killed    = commit_new && xif.commit.commit_kill;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      logic             slot_valid;
      logic             commit_hit;
      copro_entry_t     entry_q, entry_d;

      // Slot is live when it lies within count entries of the head.
      assign offset     = PTR_W'(gi) - head_q;
      assign slot_valid = {1'b0, offset} < count_q;
      assign commit_hit = xif.commit_valid && !commit_new && slot_valid &&
                          !entry_q.committed && (entry_q.id == xif.commit.id);

      always_comb begin
        entry_d = entry_q;
        if (push && (tail_q == PTR_W'(gi))) begin
          entry_d = new_entry;
        end else if (commit_hit) begin
          entry_d.committed = 1'b1;
          entry_d.killed    = xif.commit.commit_kill;
        end
      end

      always_ff @(posedge clk) begin
        entry_q <= entry_d;
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  assign head_entry   = entries[head_q];
  assign head_valid   = count_q != '0;
  assign result_valid = head_valid && head_entry.committed && !head_entry.killed;
  // Killed heads drain silently without waiting for result_ready.
  assign pop          = head_valid && head_entry.committed &&
                        (head_entry.killed || xif.result_ready);

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  assign xif.result_valid = result_valid;
  assign xif.busy         = head_valid;

  always_comb begin
    xif.result = '0;
    if (result_valid) begin
      xif.result.id      = head_entry.id;
      xif.result.data[0] = head_entry.data;
      xif.result.rd      = head_entry.rd;
      xif.result.we[0]   = head_entry.rd != 5'd0;
    end
  end

endmodule

// File: tb/tb_cv32e40px_xif_copro_ctrl.sv
// Scoreboard bench for the XIF coprocessor: stimulus queues expected results,
// a negedge monitor pops and compares every accepted result handshake.
module tb_cv32e40px_xif_copro_ctrl;
  import cv32e40px_core_v_xif_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40px_xif_copro_ctrl_if xif ();

  cv32e40px_xif_copro_ctrl #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .xif   (xif)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    logic [6:0] opc;
    opc = 7'b0001011;
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd);
    exp_t e;
    e.id = id; e.data = data; e.rd = rd; e.we = (rd != 5'd0);
    return e;
  endfunction

  task automatic set_req(input logic [31:0] instr, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] rsv);
    xif.issue_req          = '0;
    xif.issue_req.instr    = instr;
    xif.issue_req.id       = id;
    xif.issue_req.rs[0]    = a;
    xif.issue_req.rs[1]    = b;
    xif.issue_req.rs[2]    = c;
    xif.issue_req.rs_valid = rsv;
    xif.issue_req.mode     = 2'b11;
  endtask

  // One issue transaction; expects ready on the first cycle it is offered.
  task automatic issue(input string name, input logic [31:0] instr, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [2:0] rsv, input logic exp_acc, input logic exp_wb,
                       input logic commit_now, input logic kill);
    int n;
    @(posedge clk); #1;
    set_req(instr, id, a, b, c, rsv);
    xif.issue_valid = 1'b1;
    if (commit_now) begin
      xif.commit_valid       = 1'b1;
      xif.commit.id          = id;
      xif.commit.commit_kill = kill;
    end
    @(negedge clk);
    chk({name, " accept"}, 32'(xif.issue_resp.accept), 32'(exp_acc));
    chk({name, " writeback"}, 32'(xif.issue_resp.writeback), 32'(exp_wb));
    chk({name, " ready"}, 32'(xif.issue_ready), 32'd1);
    n = 0;
    while (!xif.issue_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!xif.issue_ready) chk({name, " ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    xif.issue_valid  = 1'b0;
    xif.commit_valid = 1'b0;
    $display("issue %s id=%0d accept=%0b commit=%0b kill=%0b", name, id, exp_acc, commit_now, kill);
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    @(posedge clk); #1;
    xif.commit_valid       = 1'b1;
    xif.commit.id          = id;
    xif.commit.commit_kill = kill;
    @(posedge clk); #1;
    xif.commit_valid = 1'b0;
    $display("commit id=%0d kill=%0b", id, kill);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((xif.busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, " drain_busy"}, 32'(xif.busy), 32'd0);
    chk({name, " drain_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && xif.result_valid && xif.result_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id=%0d data=%h rd=%0d, required no result",
                 xif.result.id, xif.result.data[0], xif.result.rd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result id", 32'(xif.result.id), 32'(mon_e.id));
        chk("result data", xif.result.data[0], mon_e.data);
        chk("result rd", 32'(xif.result.rd), 32'(mon_e.rd));
        chk("result we", 32'(xif.result.we[0]), 32'(mon_e.we));
        $display("result id=%0d data=%h rd=%0d we=%0b", xif.result.id, xif.result.data[0],
                 xif.result.rd, xif.result.we[0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    xif.issue_valid  = 1'b0;
    xif.commit_valid = 1'b0;
    xif.commit       = '0;
    xif.result_ready = 1'b1;
    // Rejected instr offered during reset: ready must still be 0.
    set_req(mk_instr(7'd1, 3'b000, 5'd1), 4'd0, 0, 0, 0, 3'b111);
    xif.issue_valid = 1'b1;
    @(negedge clk);
    chk("reset issue_ready", 32'(xif.issue_ready), 32'd0);
    chk("reset result_valid", 32'(xif.result_valid), 32'd0);
    chk("reset busy", 32'(xif.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    xif.issue_valid = 1'b0;
    repeat (3) @(posedge clk);

    // add3 with same-cycle commit: result one cycle later
    exp_q.push_back(mk_exp(4'd0, 32'd21, 5'd5));
    issue("add3", mk_instr(7'd0, 3'b000, 5'd5), 4'd0, 32'd5, 32'd7, 32'd9, 3'b111, 1, 1, 1, 0);
    @(negedge clk);
    chk("latency result_valid", 32'(xif.result_valid), 32'd1);
    wait_drain("add3");

    // funct7!=0 rejected; its commit is ignored
    issue("reject", mk_instr(7'd1, 3'b000, 5'd3), 4'd1, 32'd1, 32'd2, 32'd3, 3'b111, 0, 0, 0, 0);
    commit(4'd1, 1'b0);
    repeat (5) @(negedge clk);
    chk("reject busy", 32'(xif.busy), 32'd0);
    chk("reject result_valid", 32'(xif.result_valid), 32'd0);

    // min needs only rs1/rs2; rd=0 still returns a result with we=0
    exp_q.push_back(mk_exp(4'd2, 32'hFFFF_FFFF, 5'd0));
    issue("min", mk_instr(7'd0, 3'b001, 5'd0), 4'd2, 32'hFFFF_FFFF, 32'd1, 32'hDEAD_BEEF, 3'b011, 1, 0, 1, 0);

    // add3 stalls until rs3 is valid
    @(posedge clk); #1;
    set_req(mk_instr(7'd0, 3'b000, 5'd7), 4'd3, 32'd1, 32'd2, 32'd3, 3'b011);
    xif.issue_valid = 1'b1;
    @(negedge clk);
    chk("rs3wait accept", 32'(xif.issue_resp.accept), 32'd1);
    chk("rs3wait ready0", 32'(xif.issue_ready), 32'd0);
    @(negedge clk);
    chk("rs3wait ready1", 32'(xif.issue_ready), 32'd0);
    @(posedge clk); #1;
    xif.issue_req.rs_valid = 3'b111;
    @(negedge clk);
    chk("rs3wait ready_after", 32'(xif.issue_ready), 32'd1);
    @(posedge clk); #1;
    xif.issue_valid = 1'b0;
    $display("issue rs3wait id=3 accept=1");
    exp_q.push_back(mk_exp(4'd3, 32'd6, 5'd7));
    commit(4'd3, 1'b0);
    wait_drain("min_add");

    // fill all four slots uncommitted, then a fifth must stall
    issue("fill0", mk_instr(7'd0, 3'b000, 5'd1), 4'd0, 32'd10, 32'd20, 32'd30, 3'b111, 1, 1, 0, 0);
    issue("fill1", mk_instr(7'd0, 3'b001, 5'd2), 4'd1, 32'hFFFF_FFFB, 32'd3, 32'd0, 3'b111, 1, 1, 0, 0);
    issue("fill2", mk_instr(7'd0, 3'b010, 5'd3), 4'd2, 32'hFFFF_FFFB, 32'd3, 32'd0, 3'b111, 1, 1, 0, 0);
    issue("fill3", mk_instr(7'd0, 3'b011, 5'd4), 4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd1, 3'b111, 1, 1, 0, 0);
    @(posedge clk); #1;
    set_req(mk_instr(7'd0, 3'b000, 5'd6), 4'd4, 32'd1, 32'd1, 32'd1, 3'b111);
    xif.issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full ready", 32'(xif.issue_ready), 32'd0);
    end
    chk("full busy", 32'(xif.busy), 32'd1);
    @(posedge clk); #1;
    xif.issue_valid = 1'b0;
    exp_q.push_back(mk_exp(4'd0, 32'd60, 5'd1));
    exp_q.push_back(mk_exp(4'd2, 32'd3, 5'd3));
    exp_q.push_back(mk_exp(4'd3, 32'hFF00_FF01, 5'd4));
    commit(4'd0, 1'b0);
    commit(4'd1, 1'b1);
    commit(4'd2, 1'b0);
    commit(4'd3, 1'b0);
    wait_drain("fill");

    // younger commit first; older blocks it; result held while ready low
    xif.result_ready = 1'b0;
    issue("old", mk_instr(7'd0, 3'b000, 5'd8), 4'd5, 32'd1, 32'd1, 32'd1, 3'b111, 1, 1, 0, 0);
    issue("young", mk_instr(7'd0, 3'b011, 5'd9), 4'd6, 32'd1, 32'd2, 32'd4, 3'b111, 1, 1, 0, 0);
    commit(4'd6, 1'b0);
    repeat (3) @(negedge clk);
    chk("order no_result", 32'(xif.result_valid), 32'd0);
    exp_q.push_back(mk_exp(4'd5, 32'd3, 5'd8));
    exp_q.push_back(mk_exp(4'd6, 32'd7, 5'd9));
    commit(4'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold valid", 32'(xif.result_valid), 32'd1);
      chk("hold id", 32'(xif.result.id), 32'd5);
      chk("hold data", xif.result.data[0], 32'd3);
    end
    @(posedge clk); #1;
    xif.result_ready = 1'b1;
    wait_drain("order");

    // reset with three pending entries
    issue("pend7", mk_instr(7'd0, 3'b000, 5'd1), 4'd7, 32'd1, 32'd2, 32'd3, 3'b111, 1, 1, 0, 0);
    issue("pend8", mk_instr(7'd0, 3'b000, 5'd2), 4'd8, 32'd1, 32'd2, 32'd3, 3'b111, 1, 1, 0, 0);
    issue("pend9", mk_instr(7'd0, 3'b000, 5'd3), 4'd9, 32'd1, 32'd2, 32'd3, 3'b111, 1, 1, 0, 0);
    chk("pending busy", 32'(xif.busy), 32'd1);
    @(posedge clk); #1;
    set_req(mk_instr(7'd1, 3'b000, 5'd1), 4'd10, 0, 0, 0, 3'b111);
    xif.issue_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset issue_ready", 32'(xif.issue_ready), 32'd0);
    chk("midreset result_valid", 32'(xif.result_valid), 32'd0);
    chk("midreset busy", 32'(xif.busy), 32'd0);
    chk("midreset result_id", 32'(xif.result.id), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xif.issue_valid = 1'b0;
    commit(4'd7, 1'b0);
    commit(4'd8, 1'b0);
    commit(4'd9, 1'b0);
    repeat (5) @(negedge clk);
    chk("postreset busy", 32'(xif.busy), 32'd0);
    chk("postreset result_valid", 32'(xif.result_valid), 32'd0);
    issue("postreset_rej", mk_instr(7'd0, 3'b100, 5'd1), 4'd11, 0, 0, 0, 3'b111, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
